// File: rtl/sniff_pkg.sv
// Shared types and helpers for the multi-pattern stream matcher.
// Holds the FSM state enum, the byte type, the error-field width and the byte
// comparison fold used by every pattern slot.
// Optional macro SNIFF_CASE_FOLD_EN: when defined, ASCII letters compare case-insensitively.
package sniff_pkg;

  localparam int ERR_W = 6;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    CFG,
    IDLE,
    IN_PKT
  } matcher_state_t;

  // Maps a byte to its comparison key. Both stream and pattern bytes go
  // through this, so folding lower case onto upper case is sufficient.
  function automatic byte_t fold_case(input byte_t b);
    byte_t r;
    r = b;
`ifdef SNIFF_CASE_FOLD_EN
    if (b >= 8'h61 && b <= 8'h7a) r = b - 8'h20;
`endif
    return r;
  endfunction

endpackage

// File: rtl/pattern_match_unit.sv
// One pattern slot: reports whether the pattern ends at any byte lane of the current beat.
// Purely combinational (0 cycles); no flow control of its own.
// Ports: win_i history+beat window (newest byte in LSBs), win_vld_i per-byte valid,
//        pat_i pattern (byte 0 in MSBs), len_i length (0 or >MAX_LEN = off), hit_o match.
module pattern_match_unit
  import sniff_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int BYTES   = 4,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int WIN     = MAX_LEN + BYTES - 1
) (
  input  logic [WIN*8-1:0]     win_i,
  input  logic [WIN-1:0]       win_vld_i,
  input  logic [MAX_LEN*8-1:0] pat_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 hit_o
);

  logic                 enabled;
  logic [MAX_LEN-1:0]   len_mask;
  logic [MAX_LEN*8-1:0] pat_r;
  logic                 ok;

  assign enabled  = (len_i != '0) && (len_i <= LEN_W'(MAX_LEN));
  // Thermometer of the active pattern bytes; len==MAX_LEN wraps to all ones.
  assign len_mask = (MAX_LEN'(1) << len_i) - MAX_LEN'(1);
  // Right-align the pattern so its last byte sits in the LSBs, matching the
  // window where byte 0 is the newest stream byte.
  assign pat_r    = pat_i >> {(LEN_W'(MAX_LEN) - len_i), 3'b000};

  // End lane q (0 = last byte of the beat): pattern byte m-from-end lines up
  // with window byte q+m. Every compared window byte must be valid.
  always_comb begin
    hit_o = 1'b0;
    ok    = 1'b0;
    for (int q = 0; q < BYTES; q++) begin
      ok = enabled;
      for (int m = 0; m < MAX_LEN; m++) begin
        if (len_mask[m] &&
            (!win_vld_i[q+m] ||
             (fold_case(win_i[(q+m)*8 +: 8]) != fold_case(pat_r[m*8 +: 8]))))
          ok = 1'b0;
      end
      if (ok) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/multi_string_matcher.sv
// Scans an Avalon-ST stream for NUM_PATTERNS byte strings (beat-straddling), counts hits per
// packet and forwards each accepted beat to the capture write port DELAY cycles later.
// Backpressure: ready=0 only while configuring; match results appear 1 cycle after eop.
// Ports: clk/n_rst (sync active-low); data_in/valid/sop/eop/empty/error/ready stream in;
//        cfg_we/cfg_idx/cfg_str/cfg_len/update_done slot config; data_out/write_enable/addr_out
//        capture port; pkt_done/match_vec/hit_cnt packet results.
// Optional macro SNIFF_CASE_FOLD_EN: case-insensitive ASCII letter matching.
module multi_string_matcher
  import sniff_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int MAX_LEN      = 16,
  parameter int DATA_W       = 32,
  parameter int DELAY        = 5,
  parameter int CNT_W        = 64,
  parameter int ADDR_W       = 32
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [DATA_W-1:0]               data_in,
  input  logic                            valid,
  input  logic                            sop,
  input  logic                            eop,
  input  logic [$clog2(DATA_W/8)-1:0]     empty,
  input  logic [ERR_W-1:0]                error,
  output logic                            ready,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_PATTERNS)-1:0] cfg_idx,
  input  logic [MAX_LEN*8-1:0]            cfg_str,
  input  logic [$clog2(MAX_LEN+1)-1:0]    cfg_len,
  input  logic                            update_done,
  output logic [DATA_W-1:0]               data_out,
  output logic                            write_enable,
  output logic [ADDR_W-1:0]               addr_out,
  output logic                            pkt_done,
  output logic [NUM_PATTERNS-1:0]         match_vec,
  output logic [NUM_PATTERNS*CNT_W-1:0]   hit_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int WIN   = MAX_LEN + BYTES - 1;
  localparam int HB    = WIN - BYTES;  // bytes carried over from earlier beats
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  matcher_state_t state_q, state_d;

  logic [MAX_LEN*8-1:0] pat_q [NUM_PATTERNS];
  logic [LEN_W-1:0]     len_q [NUM_PATTERNS];
  logic [HB*8-1:0]      hist_q;
  logic [HB-1:0]        hvld_q;
  logic [NUM_PATTERNS-1:0] flag_q, match_q, hits, pkt_flags;
  logic [CNT_W-1:0]     cnt_q [NUM_PATTERNS];
  logic                 done_q;
  logic [DELAY-1:0]     dv_q;
  logic [DATA_W-1:0]    dd_q [DELAY];
  logic [ADDR_W-1:0]    addr_q;

  logic                 acc, cfg_wr;
  logic [WIN*8-1:0]     win;
  logic [WIN-1:0]       win_vld;
  logic [BYTES-1:0]     lane_vld;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= CFG;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CFG:    if (update_done) state_d = IDLE;
      IDLE: begin
        if (cfg_we)                     state_d = CFG;
        else if (valid && sop && !eop)  state_d = IN_PKT;
      end
      IN_PKT: if (valid && eop)         state_d = IDLE;
      default:                          state_d = CFG;
    endcase
  end

  always_comb begin
    ready = (state_q != CFG);
  end

  // In IDLE only a sop beat starts a packet; stray beats are dropped.
  assign acc    = valid && ready && (sop || (state_q == IN_PKT));
  assign cfg_wr = cfg_we && (state_q != IN_PKT);

  // ---------------- pattern slots ----------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_PATTERNS; i++) begin
        pat_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      pat_q[cfg_idx] <= cfg_str;
      len_q[cfg_idx] <= cfg_len;
    end
  end

  // ---------------- window ----------------
  always_comb begin
    lane_vld = '1;
    if (eop) lane_vld = ~((BYTES'(1) << empty) - BYTES'(1));
    win     = {hist_q, data_in};
    win_vld = {hvld_q, lane_vld};
    // A sop beat sees an empty history, so nothing matches across packets.
    if (sop) begin
      win[WIN*8-1:BYTES*8] = '0;
      win_vld[WIN-1:BYTES] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hist_q <= '0;
      hvld_q <= '0;
    end else if (acc) begin
      hist_q <= win[HB*8-1:0];
      hvld_q <= win_vld[HB-1:0];
    end
  end

  for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_slot
    pattern_match_unit #(.MAX_LEN(MAX_LEN), .BYTES(BYTES)) u_pmu (
      .win_i     (win),
      .win_vld_i (win_vld),
      .pat_i     (pat_q[g]),
      .len_i     (len_q[g]),
      .hit_o     (hits[g])
    );
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  // ---------------- packet results ----------------
  // A sop beat (including an abort-restart) discards earlier sticky flags.
  assign pkt_flags = (sop ? '0 : flag_q) | hits;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      flag_q  <= '0;
      match_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_PATTERNS; i++) cnt_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (acc) begin
        if (eop) begin
          flag_q <= '0;
          if (error == '0) begin
            done_q  <= 1'b1;
            match_q <= pkt_flags;
            for (int i = 0; i < NUM_PATTERNS; i++)
              if (pkt_flags[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          flag_q <= pkt_flags;
        end
      end
    end
  end

  // ---------------- capture delay line ----------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dv_q   <= '0;
      addr_q <= '0;
      for (int i = 0; i < DELAY; i++) dd_q[i] <= '0;
    end else begin
      dv_q    <= {dv_q[DELAY-2:0], acc};
      dd_q[0] <= data_in;
      for (int i = 1; i < DELAY; i++) dd_q[i] <= dd_q[i-1];
      // addr_out names the write in progress; step past it once it is issued.
      if (dv_q[DELAY-1]) addr_q <= addr_q + ADDR_W'(BYTES);
    end
  end

  assign data_out     = dd_q[DELAY-1];
  assign write_enable = dv_q[DELAY-1];
  assign addr_out     = addr_q;
  assign pkt_done     = done_q;
  assign match_vec    = match_q;

endmodule
